onchip_mem_block_master: RTL and testbench

- Avalon-MM master that drives the 16-bit single-port on-chip RAM slave (13-bit word address, 2-bit byteenable, fixed read latency 1).
- Accepts one block command at a time:
  - FILL writes a constant word over an address range.
  - READ streams a range out on a valid/ready interface.
- Used for RAM initialisation and for dumping RAM contents to downstream logic without the CPU.

---
 rtl/onchip_mem_block_master_pkg.sv | 29 ++
 rtl/onchip_mem_block_master_rd_skid.sv | 65 ++++++
 rtl/onchip_mem_block_master.sv | 189 ++++++++++++++++++
 tb/tb_onchip_mem_block_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_block_master_pkg.sv
// Shared types, default sizes and the wrapping address step for the on-chip RAM block master.
package onchip_mem_block_master_pkg;

  localparam int DEF_ADDR_W      = 13;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BE_W        = 2;
  localparam int DEF_DEPTH_WORDS = 8000;
  localparam int DEF_LEN_W       = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // The RAM is not a power of two deep, so the word address wraps at depth-1.
  function automatic logic [31:0] addr_inc(input logic [31:0] addr, input logic [31:0] depth);
    logic [31:0] nxt;
    if (addr == depth - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = addr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/onchip_mem_block_master_rd_skid.sv
// Two-entry FIFO holding {last, data} read words; its count feeds the read-issue credit check.
module onchip_mem_rd_skid
  import onchip_mem_block_master_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop   = i_pop & (r_count != 2'd0);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_count;

  // Head always holds the oldest word; it is cleared when the FIFO drains so stale last flags never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= i_push_data;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= i_push_data;
            r_count <= 2'd2;
          end else begin
            r_count <= r_count;
          end
        end
        2'b01: begin
          r_head  <= (r_count == 2'd2) ? r_tail : '0;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: rtl/onchip_mem_block_master.sv
// Avalon-MM master that fills or streams out word ranges of the 16-bit on-chip RAM.
// One block command at a time; read beats are credit-limited so the 2-entry skid never overflows.
module onchip_mem_block_master
  import onchip_mem_block_master_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BE_W        = DEF_BE_W,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LEN_W       = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [BE_W-1:0]   cmd_be,
  output logic              done,
  output logic              busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] address,
  output logic [BE_W-1:0]   byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              debugaccess,
  output logic              clken,
  output logic              reset_req,
  input  logic [DATA_W-1:0] readdata
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_remain;
  logic [DATA_W-1:0]   r_data;
  logic [BE_W-1:0]     r_be;
  logic                r_rvalid;
  logic                r_rlast;
  logic                r_done;
  logic                r_busy;
  logic                r_cmd_ready;

  logic                w_accept;
  logic                w_pop;
  logic [2:0]          w_load;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [1:0]          w_skid_count;
  logic                w_skid_valid;
  logic [DATA_W:0]     w_skid_head;

  assign w_accept    = cmd_valid & r_cmd_ready;
  assign w_pop       = w_skid_valid & rd_ready;
  assign w_load      = {1'b0, w_skid_count} + {2'b00, r_rvalid};
  // A word leaving the skid this cycle frees its slot, which keeps reads at one word per cycle.
  assign w_issue     = (r_state == ST_READ) &
                       ((w_load < 3'd2) | ((w_load == 3'd2) & w_pop));
  assign w_next_addr = ADDR_W'(addr_inc(32'(r_addr), 32'(DEPTH_WORDS)));

  assign cmd_ready   = r_cmd_ready;
  assign done        = r_done;
  assign busy        = r_busy;
  assign rd_valid    = w_skid_valid;
  assign rd_data     = w_skid_head[DATA_W-1:0];
  assign rd_last     = w_skid_head[DATA_W];
  assign debugaccess = write;
  assign clken       = 1'b1;
  assign reset_req   = 1'b0;

  onchip_mem_rd_skid #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (reset),
    .i_push      (r_rvalid),
    .i_push_data ({r_rlast, readdata}),
    .i_pop       (w_pop),
    .o_valid     (w_skid_valid),
    .o_data      (w_skid_head),
    .o_count     (w_skid_count)
  );

  // Slave bus beats decoded from the registered state; reads also wait for skid credit.
  always_comb begin
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    case (r_state)
      ST_FILL: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = r_addr;
        byteenable = r_be;
        writedata  = r_data;
      end
      ST_READ: begin
        chipselect = w_issue;
        address    = r_addr;
        byteenable = {BE_W{1'b1}};
      end
      default: begin
        chipselect = 1'b0;
      end
    endcase
  end

  // Command FSM; r_remain counts beats still to be put on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_done   <= 1'b0;
      r_rvalid <= w_issue;
      r_rlast  <= w_issue & (r_remain == LEN_W'(1));
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= cmd_addr;
            r_remain    <= cmd_len;
            r_data      <= cmd_data;
            r_be        <= cmd_be;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (cmd_write) begin
              r_state <= ST_FILL;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_FILL: begin
          if (r_remain == LEN_W'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_addr   <= w_next_addr;
            r_remain <= r_remain - LEN_W'(1);
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr   <= w_next_addr;
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_rvalid && (w_skid_count == 2'd0)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_block_master.sv
// Bench for onchip_mem_block_master: RAM slave model, command-level reference memory,
// table of directed commands, a mid-read reset and randomized commands.
module tb_onchip_mem_block_master;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int DEPTH = 8000;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic [BW-1:0] cmd_be;
  logic          done, busy, rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] address;
  logic [BW-1:0] byteenable;
  logic          chipselect, write, debugaccess, clken, reset_req;
  logic [DW-1:0] writedata, readdata;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] slv_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic          wr;
    int            addr;
    int            len;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    int            mode;
    int            exp_first_rd;
    int            exp_done;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  onchip_mem_block_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_be(cmd_be),
    .done(done), .busy(busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .writedata(writedata), .debugaccess(debugaccess), .clken(clken), .reset_req(reset_req),
    .readdata(readdata)
  );

  // RAM slave: writes need debugaccess, reads return data one cycle later
  always @(posedge clk) begin
    if (chipselect && write && debugaccess && (int'(address) < DEPTH)) begin
      if (byteenable[0]) slv_mem[address][7:0] <= writedata[7:0];
      if (byteenable[1]) slv_mem[address][15:8] <= writedata[15:8];
    end
    if (chipselect && !write) begin
      readdata <= (int'(address) < DEPTH) ? slv_mem[address] : 16'hDEAD;
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    if (be[0]) r[7:0] = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".rd_valid"}, rd_valid, 0);
    chk({tag, ".rd_last"}, rd_last, 0);
    chk({tag, ".rd_data"}, rd_data, 0);
    chk({tag, ".chipselect"}, chipselect, 0);
    chk({tag, ".write"}, write, 0);
    chk({tag, ".debugaccess"}, debugaccess, 0);
    chk({tag, ".address"}, address, 0);
    chk({tag, ".byteenable"}, byteenable, 0);
    chk({tag, ".writedata"}, writedata, 0);
    chk({tag, ".clken"}, clken, 1);
    chk({tag, ".reset_req"}, reset_req, 0);
  endtask

  // Issue one command and watch it to completion. mode: 0 always ready, 1 ready 1,0,0,..., 2 random.
  task automatic run_cmd(input string tag, input logic wr, input int addr, input int len,
                         input logic [DW-1:0] data, input logic [BW-1:0] be, input int mode,
                         input int exp_first_rd, input int exp_done);
    int exp_addr[$];
    logic [DW-1:0] exp_rd[$];
    int beats = 0, words = 0, issued = 0, cyc = 0;
    int done_cyc = -1, first_rd = -1, last_acc = -1, rule_done;
    logic prev_stall = 1'b0;
    logic prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (addr + i) % DEPTH;
      exp_addr.push_back(a);
      if (wr) ref_mem[a] = merge(ref_mem[a], data, be);
      else exp_rd.push_back(ref_mem[a]);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = AW'(addr); cmd_len = LW'(len);
    cmd_data = data; cmd_be = be;
    #1;
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    chk({tag, ".idle_busy"}, busy, 0);
    @(posedge clk);
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = AW'($urandom_range(0, DEPTH - 1));
      cmd_len = LW'($urandom_range(0, 5)); cmd_data = DW'($urandom); cmd_be = BW'($urandom);
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = ((cyc - 1) % 3 == 0);
        default: rd_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (prev_stall) begin
        chk({tag, ".hold_valid"}, rd_valid, 1);
        chk({tag, ".hold_data"}, rd_data, prev_data);
        chk({tag, ".hold_last"}, rd_last, prev_last);
      end
      if (chipselect) begin
        chk({tag, ".beat_write"}, write, wr);
        chk({tag, ".beat_dbg"}, debugaccess, wr);
        chk({tag, ".beat_be"}, byteenable, wr ? be : 2'b11);
        if (wr) chk({tag, ".beat_wdata"}, writedata, data);
        if (beats < exp_addr.size()) chk({tag, ".beat_addr"}, address, exp_addr[beats]);
        else chk({tag, ".extra_beat"}, beats + 1, len);
        beats++;
        if (!wr) issued++;
      end
      if (rd_valid) begin
        if (first_rd < 0) first_rd = cyc;
        if (rd_ready) begin
          if (words < exp_rd.size()) begin
            chk({tag, ".rd_data"}, rd_data, exp_rd[words]);
            chk({tag, ".rd_last"}, rd_last, (words == len - 1));
          end else begin
            chk({tag, ".extra_word"}, words + 1, exp_rd.size());
          end
          words++;
          last_acc = cyc;
        end
      end
      if (!wr) chk({tag, ".outstanding_le2"}, ((issued - words) <= 2), 1);
      prev_stall = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_last = rd_last;
      if (done) begin
        done_cyc = cyc;
        chk({tag, ".done_cs"}, chipselect, 0);
        chk({tag, ".done_ready"}, cmd_ready, 0);
        chk({tag, ".done_busy"}, busy, 1);
        cmd_valid = 1'b0;
      end else begin
        chk({tag, ".busy"}, busy, 1);
      end
    end
    cmd_valid = 1'b0;
    if (done_cyc < 0) chk({tag, ".done_timeout"}, 0, 1);
    chk({tag, ".beats"}, beats, len);
    chk({tag, ".words"}, words, wr ? 0 : len);
    if (exp_first_rd >= 0) chk({tag, ".first_rd_cycle"}, first_rd, exp_first_rd);
    if (len == 0) rule_done = 1;
    else if (wr) rule_done = len + 1;
    else rule_done = last_acc + 2;
    chk({tag, ".done_cycle"}, done_cyc, rule_done);
    if (exp_done >= 0) chk({tag, ".done_cycle_tbl"}, done_cyc, exp_done);
    @(negedge clk);
    rd_ready = 1'b1;
    #1;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".ready_back"}, cmd_ready, 1);
    chk({tag, ".busy_clear"}, busy, 0);
    chk({tag, ".post_rd_valid"}, rd_valid, 0);
  endtask

  initial begin
    int n, cyc;
    vecs[0] = '{1'b1, 16'h0010, 4, 16'hA5C3, 2'b11, 0, -1, 5};
    vecs[1] = '{1'b0, 16'h0010, 4, 16'h0000, 2'b00, 0, 3, 8};
    vecs[2] = '{1'b0, 16'h0010, 6, 16'h0000, 2'b00, 1, 3, -1};
    vecs[3] = '{1'b1, 7998, 4, 16'h1234, 2'b01, 0, -1, 5};
    vecs[4] = '{1'b0, 7998, 4, 16'h0000, 2'b00, 0, 3, 8};
    vecs[5] = '{1'b1, 5, 0, 16'hFFFF, 2'b11, 0, -1, 1};
    vecs[6] = '{1'b0, 5, 0, 16'h0000, 2'b00, 0, -1, 1};
    vecs[7] = '{1'b1, 100, 1, 16'hBEEF, 2'b10, 0, -1, 2};
    vecs[8] = '{1'b0, 100, 1, 16'h0000, 2'b00, 1, 3, 6};

    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      slv_mem[i] = v;
      ref_mem[i] = v;
    end
    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_data = '0; cmd_be = '0; rd_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("por_release");

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].data,
              vecs[i].be, vecs[i].mode, vecs[i].exp_first_rd, vecs[i].exp_done);
    end

    // reset during a READ after three words have been taken
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h0010; cmd_len = 14'd6; rd_ready = 1'b1;
    @(posedge clk);
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
      #1;
      if (rd_valid && rd_ready) n++;
    end
    chk("midrst.words_before", n, 3);
    @(negedge clk);
    reset = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("midrst_release");
    run_cmd("after_rst", 1'b0, 16'h0010, 3, 16'h0000, 2'b00, 0, 3, 7);

    for (int k = 0; k < 25; k++) begin
      logic rwr;
      int raddr, rlen, rmode;
      rwr = 1'($urandom);
      raddr = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 12, DEPTH - 1)
                                          : $urandom_range(0, DEPTH - 1);
      rlen = $urandom_range(0, 12);
      rmode = $urandom_range(0, 2);
      run_cmd($sformatf("rnd%0d", k), rwr, raddr, rlen, DW'($urandom), BW'($urandom),
              rmode, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
